// File: rtl/uart_cmd_parse_pkg.sv
// Shared sequencer definitions: widths, ASCII command bytes, parser states
// and the hex-digit decode helper used by the UART command parser.
package uart_cmd_parse_pkg;

  localparam int DP_WIDTH_DFLT = 16;
  localparam int RN_WIDTH_DFLT = 4;

  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG_W,
    ST_REG_R,
    ST_DATA,
    ST_TERM_W,
    ST_TERM_R,
    ST_RD_WAIT,
    ST_SKIP
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_t;

  // Letters A-F and a-f share low nibbles 1..6, so adding 9 yields 10..15.
  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t res;
    res = '{valid: 1'b0, nib: 4'h0};
    if (c >= 8'h30 && c <= 8'h39) begin
      res = '{valid: 1'b1, nib: c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      res = '{valid: 1'b1, nib: c[3:0] + 4'd9};
    end
    return res;
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parse_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases two clocks after the
// external reset is removed so the parser never leaves reset mid-edge.
module uart_cmd_parse_rst_sync (
  input  logic clk,
  input  logic rst,
  output logic rst_n_sync
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync = sync_q[1];

endmodule

// File: rtl/uart_cmd_parse.sv
// ASCII command parser: "W<reg><data>TERM" issues a register write strobe,
// "R<reg>TERM" issues a read request, deferred while the transmit stage is busy.
// Byte interface: a byte is consumed on every cycle with i_rx_valid high; there
// is no back-pressure. Output strobes are single-cycle and registered.
module uart_cmd_parse
  import uart_cmd_parse_pkg::*;
#(
  parameter int DP_WIDTH = DP_WIDTH_DFLT,
  parameter int RN_WIDTH = RN_WIDTH_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_rd_busy,
  output logic                o_wr_stb,
  output logic [RN_WIDTH-1:0] o_wr_reg,
  output logic [DP_WIDTH-1:0] o_wr_data,
  output logic                o_rd_stb,
  output logic [RN_WIDTH-1:0] o_rd_reg,
  output logic                o_err,
  output state_t              o_dbg_state
);

  localparam int NUM_NIB = DP_WIDTH / 4;
  localparam int CNT_W   = $clog2(NUM_NIB + 1);

  logic                rst_n;
  state_t              state_q, state_d;
  logic [DP_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RN_WIDTH-1:0] reg_q, reg_d;
  logic                wr_req, rd_req, err_req;
  hex_t                hx;
  logic                term;

  uart_cmd_parse_rst_sync u_rst_sync (
    .clk        (clk),
    .rst        (rst),
    .rst_n_sync (rst_n)
  );

  assign hx          = hex_decode(i_rx_data);
  assign term        = is_term(i_rx_data);
  assign o_dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    err_req = 1'b0;
    unique case (state_q)
      ST_IDLE: if (i_rx_valid) begin
        if (i_rx_data == ASCII_W) begin
          state_d = ST_REG_W;
        end else if (i_rx_data == ASCII_R) begin
          state_d = ST_REG_R;
        end else if (!term) begin
          err_req = 1'b1;
          state_d = ST_SKIP;
        end
      end
      ST_REG_W, ST_REG_R: if (i_rx_valid) begin
        if (hx.valid) begin
          reg_d   = RN_WIDTH'(hx.nib);
          cnt_d   = '0;
          state_d = (state_q == ST_REG_W) ? ST_DATA : ST_TERM_R;
        end else begin
          // A terminator already ends the broken command, so no skip needed.
          err_req = 1'b1;
          state_d = term ? ST_IDLE : ST_SKIP;
        end
      end
      ST_DATA: if (i_rx_valid) begin
        if (hx.valid) begin
          data_d = DP_WIDTH'({data_q, hx.nib});
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_NIB - 1)) begin
            cnt_d   = '0;
            state_d = ST_TERM_W;
          end
        end else begin
          err_req = 1'b1;
          state_d = term ? ST_IDLE : ST_SKIP;
        end
      end
      ST_TERM_W: if (i_rx_valid) begin
        if (term) begin
          wr_req  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_req = 1'b1;
          state_d = ST_SKIP;
        end
      end
      ST_TERM_R: if (i_rx_valid) begin
        if (term) begin
          if (i_rd_busy) begin
            state_d = ST_RD_WAIT;
          end else begin
            rd_req  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          err_req = 1'b1;
          state_d = ST_SKIP;
        end
      end
      ST_RD_WAIT: begin
        // Bytes arriving here are dropped; the pending read survives them.
        err_req = i_rx_valid;
        if (!i_rd_busy) begin
          rd_req  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: if (i_rx_valid && term) begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      reg_q     <= '0;
      o_wr_stb  <= 1'b0;
      o_rd_stb  <= 1'b0;
      o_err     <= 1'b0;
      o_wr_reg  <= '0;
      o_wr_data <= '0;
      o_rd_reg  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      reg_q    <= reg_d;
      o_wr_stb <= wr_req;
      o_rd_stb <= rd_req;
      o_err    <= err_req;
      if (wr_req) begin
        o_wr_reg  <= reg_q;
        o_wr_data <= data_q;
      end
      if (rd_req) begin
        o_rd_reg <= reg_q;
      end
    end
  end

endmodule
